// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD up/down counter with synchronous clear and terminal-count flag.
// Optional synchronous load with per-digit saturation when BCD_COUNTER_LOAD_EN is defined.
module bcd_cascade_counter #(
  parameter int DIGITS  = 2,
  parameter int TOP_MAX = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up_dn,
  input  logic                clr,
`ifdef BCD_COUNTER_LOAD_EN
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                tc
);

  localparam int         W   = 4 * DIGITS;
  localparam logic [3:0] TOP = 4'(TOP_MAX);

  logic [W-1:0] stepped;
  logic [W-1:0] count_nxt;
  logic [3:0]   dig;
  logic [3:0]   dmax;
  logic         up_run;
  logic         dn_run;
  logic         all_max;
  logic         all_zero;

  // Ripple enables: a digit steps only while every lower digit is at its wrap point.
  always_comb begin
    stepped = count;
    dig     = '0;
    dmax    = '0;
    up_run  = 1'b1;
    dn_run  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig  = count[4*i +: 4];
      dmax = (i == DIGITS - 1) ? TOP : 4'd9;
      if (up_dn && up_run)
        stepped[4*i +: 4] = (dig == dmax) ? 4'd0 : dig + 4'd1;
      if (!up_dn && dn_run)
        stepped[4*i +: 4] = (dig == 4'd0) ? dmax : dig - 4'd1;
      up_run = up_run & (dig == dmax);
      dn_run = dn_run & (dig == 4'd0);
    end
    all_max  = up_run;
    all_zero = dn_run;
  end

`ifdef BCD_COUNTER_LOAD_EN
  logic [W-1:0] clamped;
  logic [3:0]   ld_dig;
  logic [3:0]   ld_max;

  always_comb begin
    clamped = load_val;
    ld_dig  = '0;
    ld_max  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ld_dig = load_val[4*i +: 4];
      ld_max = (i == DIGITS - 1) ? TOP : 4'd9;
      if (ld_dig > ld_max)
        clamped[4*i +: 4] = ld_max;
    end
  end
`endif

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
`ifdef BCD_COUNTER_LOAD_EN
    else if (load)
      count_nxt = clamped;
`endif
    else if (en)
      count_nxt = stepped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_nxt;
  end

  // Gated by rst_n so the all-zero reset value cannot flag a down-count wrap.
`ifdef BCD_COUNTER_LOAD_EN
  assign tc = rst_n & en & ~clr & ~load & (up_dn ? all_max : all_zero);
`else
  assign tc = rst_n & en & ~clr & (up_dn ? all_max : all_zero);
`endif

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed bench for bcd_cascade_counter: a 2-digit 0..99 instance and a 0..59 instance.
module tb_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic [7:0] count_b;
  logic       tc_b;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int nb     = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(2), .TOP_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
`ifdef BCD_COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .count(count), .tc(tc)
  );

  bcd_cascade_counter #(.DIGITS(2), .TOP_MAX(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
`ifdef BCD_COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .count(count_b), .tc(tc_b)
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Each iteration: check the pre-edge state, take one enabled edge, advance the model.
  task automatic steps(input int k, input logic dir);
    for (int i = 0; i < k; i++) begin
      en = 1'b1; up_dn = dir; clr = 1'b0; load = 1'b0;
      #1;
      check("step_count", 32'(count), 32'(bcd(n)));
      check("step_tc", 32'(tc), 32'(dir ? (n == 99) : (n == 0)));
      @(posedge clk); #1;
      n = dir ? (n + 1) % 100 : (n + 99) % 100;
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    #2;
    check("rst_count", 32'(count), 32'h00);
    check("rst_tc", 32'(tc), 32'h0);
    check("rst_count_b", 32'(count_b), 32'h00);
    @(posedge clk); #1;
    check("rst_hold", 32'(count), 32'h00);
    rst_n = 1'b1; en = 1'b0; up_dn = 1'b1;
    n = 0;

    // Full up sweep 00..99 and wrap back to 00
    steps(100, 1'b1);
    #1 check("up_wrap", 32'(count), 32'h00);

    // Full down sweep 00 -> 99 .. 00, covers 10 -> 09
    steps(100, 1'b0);
    #1 check("down_wrap", 32'(count), 32'h00);

    // Direction changes with no dead cycle
    steps(3, 1'b1);
    steps(1, 1'b0);
    steps(2, 1'b1);
    steps(5, 1'b0);
    #1 check("dir_mix", 32'(count), 32'h99);

    // Hold with en low
    en = 1'b0; up_dn = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("hold", 32'(count), 32'h99);
    check("hold_tc", 32'(tc), 32'h0);

    // clr at 99 with en up: no tc, clears
    en = 1'b1; up_dn = 1'b1; clr = 1'b1;
    #1 check("clr99_tc", 32'(tc), 32'h0);
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b0; n = 0;
    check("clr99_count", 32'(count), 32'h00);

    // clr with en at 47
    steps(47, 1'b1);
    en = 1'b1; up_dn = 1'b1; clr = 1'b1;
    #1 check("clr47_tc", 32'(tc), 32'h0);
    check("clr47_pre", 32'(count), 32'h47);
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b0; n = 0;
    check("clr47_count", 32'(count), 32'h00);

`ifdef BCD_COUNTER_LOAD_EN
    // Saturating loads, load beats en, clr beats load
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'hAF;
    #1 check("load_tc", 32'(tc), 32'h0);
    @(posedge clk); #1;
    check("load_AF", 32'(count), 32'h99);
    load_val = 8'h35;
    @(posedge clk); #1;
    check("load_35", 32'(count), 32'h35);
    load_val = 8'h6C;
    @(posedge clk); #1;
    check("load_6C", 32'(count), 32'h69);
    check("load_b_6C", 32'(count_b), 32'h59);
    clr = 1'b1; load_val = 8'h12;
    @(posedge clk); #1;
    check("clr_over_load", 32'(count), 32'h00);
    clr = 1'b0; load = 1'b0; en = 1'b0; n = 0;
`endif

    // Asynchronous reset mid-count at 62
    steps(62, 1'b1);
    check("pre_rst62", 32'(count), 32'h62);
    en = 1'b1; up_dn = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'(count), 32'h00);
    check("async_rst_tc", 32'(tc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; up_dn = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("post_rst", 32'(count), 32'h01);

    // TOP_MAX=5 instance: 0..59, never 6x
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    nb = 0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 120; i++) begin
      #1;
      check("b_count", 32'(count_b), 32'(bcd(nb)));
      check("b_tc", 32'(tc_b), 32'(nb == 59));
      check("b_top_le5", 32'(count_b[7:4] <= 4'd5), 32'h1);
      @(posedge clk); #1;
      nb = (nb + 1) % 60;
    end
    up_dn = 1'b0;
    #1 check("b_down_tc", 32'(tc_b), 32'h1);
    @(posedge clk); #1;
    check("b_down_wrap", 32'(count_b), 32'h59);
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD digits, legal range 1..8.
REQ-002 Parameter TOP_MAX, default 9: maximum value of the most-significant digit, legal range 1..9. For example, DIGITS=2 with TOP_MAX=5 gives a 0..59 counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up_dn  input  1  direction: 1 counts up, 0 counts down.
REQ-007 clr  input  1  synchronous clear to zero.
REQ-008 load  input  1  synchronous load of load_val; present only with BCD_COUNTER_LOAD_EN.
REQ-009 load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0]; present only with BCD_COUNTER_LOAD_EN.
REQ-010 count  output  4*DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-011 tc  output  1  combinational terminal-count flag.

Function
REQ-012 Each digit i (bits [4i+3:4i]) SHALL only ever hold 0..9; the top digit SHALL only ever hold 0..TOP_MAX.
REQ-013 Priority per cycle SHALL be clr > load > en; with none of them active, count holds.
REQ-014 Up step: digit 0 SHALL increment. Digit i>0 SHALL increment only when all lower digits are at their maximum. A digit at its maximum that steps SHALL wrap to 0.
REQ-015 Down step: digit 0 SHALL decrement. Digit i>0 SHALL decrement only when all lower digits are 0. A digit at 0 that steps SHALL wrap to its maximum (9, or TOP_MAX for the top digit).
REQ-016 Full-range wrap: up from the maximum value (TOP_MAX, 9, ..., 9) SHALL give all zeros; down from all zeros SHALL give the maximum value. Both happen in a single cycle.
REQ-017 tc SHALL equal en & (up_dn ? count==max : count==0) & ~clr & ~load. It is high exactly in the cycle whose edge wraps the counter.
REQ-018 Latency: count SHALL reflect a step, clear or load one clock edge after the control is sampled high.
REQ-019 up_dn SHALL be sampled every cycle; a direction change takes effect on the very next step with no dead cycle.
REQ-020 With DIGITS=1, the single digit SHALL use TOP_MAX as its maximum.

Reset
REQ-021 rst_n low SHALL force count to all zeros immediately, without waiting for clk.
REQ-022 tc SHALL be 0 while rst_n is low.
REQ-023 Reset may be asserted mid-count. After deassertion, the first enabled edge SHALL count from 0.
REQ-024 Reset deassertion is synchronised externally; the block itself needs no deassertion synchroniser.

Configuration
REQ-025 With macro BCD_COUNTER_LOAD_EN defined:
- load and load_val ports exist.
- On a load, each digit value above 9 SHALL be stored as 9.
- A top digit above TOP_MAX SHALL be stored as TOP_MAX.
REQ-026 With BCD_COUNTER_LOAD_EN undefined:
- load and load_val ports are absent.
- Load logic is absent; priority reduces to clr > en.

Verification (DIGITS=2, TOP_MAX=9 unless stated)
REQ-027 Reset then en=1, up_dn=1 for 100 cycles -> count steps 00..99, returns to 00, and tc is high only in the cycle where count=99.
REQ-028 Preset count to 00, then en=1, up_dn=0 -> count 99, 98, ..., tc high at 00; boundary 10 -> 09 is checked.
REQ-029 TOP_MAX=5 up-count -> 59 wraps to 00; count never shows 6x in 120 cycles.
REQ-030 At count=47 assert clr and en together -> next count 00; tc low during that cycle.
REQ-031 With BCD_COUNTER_LOAD_EN: load_val=0xAF, load=1, en=1 -> count 99 next edge. Then load_val=0x35 -> count 35.
REQ-032 At count=62, drop rst_n between clock edges -> count 00 immediately. After rst_n rises and en=1, the next edge gives 01.
